// File: rtl/tsclk_gen_multi_pkg.sv
// Package tsclk_pkg: shared constants and helpers for the multi-channel timestamp
// clock generator.
//   - Register map: CTRL at 0x0, HALF[ch] at 0x1+ch, PHASE[ch] at 0x9+ch.
//   - CTRL bit indices: bit0 enable, bit1 soft sync (write-only pulse).
//   - Reset defaults for the global enable state.
//   - decode_addr(): turns a config address into a register select plus channel.
package tsclk_pkg;

    localparam int         ADDR_W          = 4;
    localparam logic [3:0] ADDR_CTRL       = 4'h0;
    localparam logic [3:0] ADDR_HALF_BASE  = 4'h1;
    localparam logic [3:0] ADDR_PHASE_BASE = 4'h9;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_SYNC_BIT   = 1;

    localparam logic RST_RUNNING = 1'b1;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_HALF,
        SEL_PHASE
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [2:0] ch;
    } reg_dec_t;

    // Addresses past the last channel of either bank decode to SEL_NONE,
    // so writes to them are dropped.
    function automatic reg_dec_t decode_addr(input logic [3:0] addr, input int nch);
        reg_dec_t d;
        d.sel = SEL_NONE;
        d.ch  = '0;
        if (addr == ADDR_CTRL) begin
            d.sel = SEL_CTRL;
        end else if (int'(addr) >= int'(ADDR_HALF_BASE) &&
                     int'(addr) <  int'(ADDR_HALF_BASE) + nch) begin
            d.sel = SEL_HALF;
            d.ch  = 3'(addr - ADDR_HALF_BASE);
        end else if (int'(addr) >= int'(ADDR_PHASE_BASE) &&
                     int'(addr) <  int'(ADDR_PHASE_BASE) + nch) begin
            d.sel = SEL_PHASE;
            d.ch  = 3'(addr - ADDR_PHASE_BASE);
        end
        return d;
    endfunction

endpackage

// File: rtl/tsclk_gen_multi_if.sv
// tsclk_gen_multi_if: configuration / restart bus into the timestamp clock generator.
//   cfg_we     write strobe, one cycle per write
//   cfg_addr   register address
//   cfg_wdata  write data (DIV_W bits)
//   sync_req   synchronous restart pulse
// master drives the bus (controller side), slave receives it (generator side).
interface tsclk_gen_multi_if
    import tsclk_pkg::*;
#(
    parameter int DIV_W = 8
);
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DIV_W-1:0]  cfg_wdata;
    logic              sync_req;

    modport master (output cfg_we, cfg_addr, cfg_wdata, sync_req);
    modport slave  (input  cfg_we, cfg_addr, cfg_wdata, sync_req);
endinterface

// File: rtl/tsclk_div_channel.sv
// tsclk_div_channel: one glitch-free programmable divider channel.
// Ports:
//   timestamp_int_clk  clock
//   cpu_resetn         asynchronous active-low reset
//   en                 effective enable for this cycle
//   sync               restart: output low, counter preloaded from phase
//   half_we/phase_we   register write strobes for this channel
//   wdata              write data shared by both registers
//   clk_out            divided clock, straight from a flop
//   rise               high in the cycle whose edge takes clk_out 0->1
module tsclk_div_channel #(
    parameter int DIV_W = 8
) (
    input  logic             timestamp_int_clk,
    input  logic             cpu_resetn,
    input  logic             en,
    input  logic             sync,
    input  logic             half_we,
    input  logic             phase_we,
    input  logic [DIV_W-1:0] wdata,
    output logic             clk_out,
    output logic             rise
);

    logic [DIV_W-1:0] shadow_q, shadow_nxt;
    logic [DIV_W-1:0] phase_q, phase_nxt;
    logic [DIV_W-1:0] h_act_q, h_act_nxt;
    logic [DIV_W-1:0] cnt_q, cnt_nxt;
    logic             out_q, out_nxt;

    // Next-state logic. A new half-period only reaches h_act at a toggle, so no
    // half-period is ever cut short or stretched. A restart sees a write made in
    // the same cycle. When disabled, a high output still runs out its half-period
    // and falls; a low output freezes with its counter.
    always_comb begin
        shadow_nxt = half_we  ? wdata : shadow_q;
        phase_nxt  = phase_we ? wdata : phase_q;
        h_act_nxt  = h_act_q;
        cnt_nxt    = cnt_q;
        out_nxt    = out_q;
        if (sync) begin
            out_nxt   = 1'b0;
            h_act_nxt = shadow_nxt;
            cnt_nxt   = (phase_nxt < shadow_nxt) ? phase_nxt : shadow_nxt;
        end else if (en || out_q) begin
            if (cnt_q == h_act_q) begin
                out_nxt   = ~out_q;
                cnt_nxt   = '0;
                h_act_nxt = shadow_q;
            end else begin
                cnt_nxt = cnt_q + DIV_W'(1);
            end
        end
    end

    // State register; reset gives h=0, i.e. the legacy divide-by-2.
    always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            shadow_q <= '0;
            phase_q  <= '0;
            h_act_q  <= '0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_nxt;
            phase_q  <= phase_nxt;
            h_act_q  <= h_act_nxt;
            cnt_q    <= cnt_nxt;
            out_q    <= out_nxt;
        end
    end

    assign clk_out = out_q;
    assign rise    = out_nxt & ~out_q;

endmodule

// File: rtl/tsclk_gen_multi.sv
// tsclk_gen_multi: NCH-channel timestamp clock generator in the timestamp_int_clk
// domain, with a timestamp counter following channel 0.
// Ports:
//   timestamp_int_clk  clock
//   cpu_resetn         asynchronous active-low reset
//   cfg                config bus (tsclk_gen_multi_if.slave), already synchronised
//   ts_clk_out         divided clocks, one flop per channel
//   ts_count           channel-0 rising-edge count
//   ts_overflow        one-cycle pulse when ts_count wraps
//   ts_running         global enable state
//   ts_count_gray      Gray-coded ts_count (only with TSCLK_GRAY_EN defined)
// Optional feature macro: TSCLK_GRAY_EN.
module tsclk_gen_multi
    import tsclk_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DIV_W = 8,
    parameter int TS_W  = 16
) (
    input  logic               timestamp_int_clk,
    input  logic               cpu_resetn,
    tsclk_gen_multi_if.slave   cfg,
    output logic [NCH-1:0]     ts_clk_out,
    output logic [TS_W-1:0]    ts_count,
    output logic               ts_overflow,
    output logic               ts_running
`ifdef TSCLK_GRAY_EN
    ,
    output logic [TS_W-1:0]    ts_count_gray
`endif
);

    // Channel whose rising edges drive the timestamp counter.
    localparam logic [NCH-1:0] TS_SRC_MASK = NCH'(1);

    reg_dec_t         dec;
    logic             ctrl_we;
    logic             running_q, running_nxt;
    logic             sync;
    logic [NCH-1:0]   half_we, phase_we, ch_rise;
    logic [TS_W-1:0]  ts_count_q, ts_count_nxt;
    logic             ts_overflow_q, ts_overflow_nxt;

    // Register decode and global control. Enabling from the disabled state
    // counts as a restart; restart requests are dropped while disabled.
    always_comb begin
        dec         = decode_addr(cfg.cfg_addr, NCH);
        ctrl_we     = cfg.cfg_we && (dec.sel == SEL_CTRL);
        running_nxt = ctrl_we ? cfg.cfg_wdata[CTRL_ENABLE_BIT] : running_q;
        sync        = running_nxt &&
                      (cfg.sync_req ||
                       (ctrl_we && cfg.cfg_wdata[CTRL_SYNC_BIT]) ||
                       (ctrl_we && cfg.cfg_wdata[CTRL_ENABLE_BIT] && !running_q));
        for (int i = 0; i < NCH; i++) begin
            half_we[i]  = cfg.cfg_we && (dec.sel == SEL_HALF)  && (int'(dec.ch) == i);
            phase_we[i] = cfg.cfg_we && (dec.sel == SEL_PHASE) && (int'(dec.ch) == i);
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        tsclk_div_channel #(.DIV_W(DIV_W)) u_ch (
            .timestamp_int_clk (timestamp_int_clk),
            .cpu_resetn        (cpu_resetn),
            .en                (running_nxt),
            .sync              (sync),
            .half_we           (half_we[ch]),
            .phase_we          (phase_we[ch]),
            .wdata             (cfg.cfg_wdata),
            .clk_out           (ts_clk_out[ch]),
            .rise              (ch_rise[ch])
        );
    end

    // Timestamp counter: a restart clears it and suppresses a coincident wrap pulse.
    always_comb begin
        ts_count_nxt    = ts_count_q;
        ts_overflow_nxt = 1'b0;
        if (sync) begin
            ts_count_nxt = '0;
        end else if (|(ch_rise & TS_SRC_MASK)) begin
            ts_count_nxt    = ts_count_q + TS_W'(1);
            ts_overflow_nxt = &ts_count_q;
        end
    end

    always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            running_q     <= RST_RUNNING;
            ts_count_q    <= '0;
            ts_overflow_q <= 1'b0;
        end else begin
            running_q     <= running_nxt;
            ts_count_q    <= ts_count_nxt;
            ts_overflow_q <= ts_overflow_nxt;
        end
    end

    assign ts_count    = ts_count_q;
    assign ts_overflow = ts_overflow_q;
    assign ts_running  = running_q;

`ifdef TSCLK_GRAY_EN
    // Gray code is formed from the next count so it lines up with ts_count.
    logic [TS_W-1:0] gray_q;
    always_ff @(posedge timestamp_int_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            gray_q <= '0;
        end else begin
            gray_q <= ts_count_nxt ^ (ts_count_nxt >> 1);
        end
    end
    assign ts_count_gray = gray_q;
`endif

endmodule
